// File: rtl/ctrl_rx_cmd.sv
// Command decoder behind the UART receiver: parses framed byte commands into
// register-file writes/reads and ALU operations, and hands results to the TX side.
module ctrl_rx_cmd #(
  parameter int WIDTH   = 8,
  parameter int ADDR    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [WIDTH-1:0]     i_rx_p_data,
  input  logic                 i_rx_d_vld,
  input  logic [WIDTH-1:0]     i_rf_rd_data,
  input  logic                 i_rf_rd_data_vld,
  input  logic [2*WIDTH-1:0]   i_alu_out,
  input  logic                 i_alu_out_vld,
  output logic [ADDR-1:0]      o_rf_addr,
  output logic                 o_rf_wr_en,
  output logic                 o_rf_rd_en,
  output logic [WIDTH-1:0]     o_rf_wr_data,
  output logic                 o_alu_en,
  output logic [3:0]           o_alu_fun,
  output logic                 o_clk_gate_en,
  output logic                 o_uart_rf_send,
  output logic [WIDTH-1:0]     o_uart_send_rf_data,
  output logic                 o_uart_alu_send,
  output logic [2*WIDTH-1:0]   o_uart_send_alu_data,
  output logic                 o_cmd_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [WIDTH-1:0] OP_WR  = WIDTH'(8'hAA);
  localparam logic [WIDTH-1:0] OP_RD  = WIDTH'(8'hBB);
  localparam logic [WIDTH-1:0] OP_ALU = WIDTH'(8'hCC);
  localparam logic [WIDTH-1:0] OP_FUN = WIDTH'(8'hDD);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_DATA,
    S_RD_ADDR,
    S_RD_WAIT,
    S_OPA,
    S_OPB,
    S_FUN,
    S_ALU_WAIT
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [ADDR-1:0]      r_addr;
  logic [WIDTH-1:0]     r_rf;
  logic [2*WIDTH-1:0]   r_alu;
  logic [CW-1:0]        r_cnt;
  logic                 r_rf_send;
  logic                 r_alu_send;
  logic                 r_cmd_err;

  logic                 w_opcode_ok;
  logic                 w_in_wait;
  logic                 w_last_wait;

  logic [ADDR-1:0]      w_rf_addr;
  logic                 w_rf_wr_en;
  logic                 w_rf_rd_en;
  logic [WIDTH-1:0]     w_rf_wr_data;
  logic                 w_alu_en;
  logic [3:0]           w_alu_fun;
  logic                 w_clk_gate_en;

  assign w_opcode_ok = (i_rx_p_data == OP_WR)  || (i_rx_p_data == OP_RD) ||
                       (i_rx_p_data == OP_ALU) || (i_rx_p_data == OP_FUN);
  assign w_in_wait   = (r_state == S_RD_WAIT) || (r_state == S_ALU_WAIT);
  // r_cnt counts completed wait cycles, so TIMEOUT-1 marks the final accepted cycle
  assign w_last_wait = (r_cnt == CW'(TIMEOUT - 1));

  // state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_rx_d_vld) begin
          if (i_rx_p_data == OP_WR)       w_next = S_WR_ADDR;
          else if (i_rx_p_data == OP_RD)  w_next = S_RD_ADDR;
          else if (i_rx_p_data == OP_ALU) w_next = S_OPA;
          else if (i_rx_p_data == OP_FUN) w_next = S_FUN;
        end
      end
      S_WR_ADDR:  if (i_rx_d_vld) w_next = S_WR_DATA;
      S_WR_DATA:  if (i_rx_d_vld) w_next = S_IDLE;
      S_RD_ADDR:  if (i_rx_d_vld) w_next = S_RD_WAIT;
      S_OPA:      if (i_rx_d_vld) w_next = S_OPB;
      S_OPB:      if (i_rx_d_vld) w_next = S_FUN;
      S_FUN:      if (i_rx_d_vld) w_next = S_ALU_WAIT;
      S_RD_WAIT:  if (i_rf_rd_data_vld || w_last_wait) w_next = S_IDLE;
      S_ALU_WAIT: if (i_alu_out_vld || w_last_wait) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Strobes are combinational on the accepted byte; reset masks them so an
  // aborted frame never leaks a write or ALU start.
  always_comb begin
    w_rf_addr     = '0;
    w_rf_wr_en    = 1'b0;
    w_rf_rd_en    = 1'b0;
    w_rf_wr_data  = '0;
    w_alu_en      = 1'b0;
    w_alu_fun     = '0;
    w_clk_gate_en = 1'b0;
    if (!i_rst) begin
      case (r_state)
        S_WR_DATA: begin
          if (i_rx_d_vld) begin
            w_rf_wr_en   = 1'b1;
            w_rf_addr    = r_addr;
            w_rf_wr_data = i_rx_p_data;
          end
        end
        S_RD_ADDR: begin
          if (i_rx_d_vld) begin
            w_rf_rd_en = 1'b1;
            w_rf_addr  = i_rx_p_data[ADDR-1:0];
          end
        end
        S_OPA: begin
          if (i_rx_d_vld) begin
            w_rf_wr_en   = 1'b1;
            w_rf_addr    = ADDR'(0);
            w_rf_wr_data = i_rx_p_data;
          end
        end
        S_OPB: begin
          if (i_rx_d_vld) begin
            w_rf_wr_en   = 1'b1;
            w_rf_addr    = ADDR'(1);
            w_rf_wr_data = i_rx_p_data;
          end
        end
        S_FUN: begin
          w_clk_gate_en = 1'b1;
          if (i_rx_d_vld) begin
            w_alu_en  = 1'b1;
            w_alu_fun = i_rx_p_data[3:0];
          end
        end
        S_ALU_WAIT: w_clk_gate_en = 1'b1;
        default: ;
      endcase
    end
  end

  // datapath registers, wait counter and registered pulses
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr     <= '0;
      r_rf       <= '0;
      r_alu      <= '0;
      r_cnt      <= '0;
      r_rf_send  <= 1'b0;
      r_alu_send <= 1'b0;
      r_cmd_err  <= 1'b0;
    end else begin
      r_rf_send  <= 1'b0;
      r_alu_send <= 1'b0;
      r_cmd_err  <= 1'b0;
      r_cnt      <= w_in_wait ? r_cnt + CW'(1) : '0;
      case (r_state)
        S_IDLE: begin
          if (i_rx_d_vld && !w_opcode_ok) r_cmd_err <= 1'b1;
        end
        S_WR_ADDR: begin
          if (i_rx_d_vld) r_addr <= i_rx_p_data[ADDR-1:0];
        end
        S_RD_WAIT: begin
          if (i_rf_rd_data_vld) begin
            r_rf      <= i_rf_rd_data;
            r_rf_send <= 1'b1;
          end else if (w_last_wait) begin
            r_cmd_err <= 1'b1;
          end
        end
        S_ALU_WAIT: begin
          if (i_alu_out_vld) begin
            r_alu      <= i_alu_out;
            r_alu_send <= 1'b1;
          end else if (w_last_wait) begin
            r_cmd_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_rf_addr            = w_rf_addr;
  assign o_rf_wr_en           = w_rf_wr_en;
  assign o_rf_rd_en           = w_rf_rd_en;
  assign o_rf_wr_data         = w_rf_wr_data;
  assign o_alu_en             = w_alu_en;
  assign o_alu_fun            = w_alu_fun;
  assign o_clk_gate_en        = w_clk_gate_en;
  assign o_uart_rf_send       = r_rf_send;
  assign o_uart_send_rf_data  = r_rf;
  assign o_uart_alu_send      = r_alu_send;
  assign o_uart_send_alu_data = r_alu;
  assign o_cmd_err            = r_cmd_err;

endmodule

// File: tb/tb_ctrl_rx_cmd.sv
// Scoreboard bench for ctrl_rx_cmd: expected strobe/pulse events are queued as
// bytes are driven and matched against what the monitor observes each cycle.
module tb_ctrl_rx_cmd;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_p_data;
  logic        rx_d_vld;
  logic [7:0]  rf_rd_data;
  logic        rf_rd_data_vld;
  logic [15:0] alu_out;
  logic        alu_out_vld;
  logic [3:0]  o_rf_addr;
  logic        o_rf_wr_en;
  logic        o_rf_rd_en;
  logic [7:0]  o_rf_wr_data;
  logic        o_alu_en;
  logic [3:0]  o_alu_fun;
  logic        o_clk_gate_en;
  logic        o_uart_rf_send;
  logic [7:0]  o_uart_send_rf_data;
  logic        o_uart_alu_send;
  logic [15:0] o_uart_send_alu_data;
  logic        o_cmd_err;

  int checks   = 0;
  int failures = 0;
  logic [31:0] sb_q[$];

  localparam logic [3:0] K_WR = 4'd1, K_RD = 4'd2, K_ALU = 4'd3,
                         K_RFS = 4'd4, K_ALS = 4'd5, K_ERR = 4'd6;

  ctrl_rx_cmd #(.WIDTH(8), .ADDR(4), .TIMEOUT(16)) dut (
    .i_clk                (clk),
    .i_rst                (rst),
    .i_rx_p_data          (rx_p_data),
    .i_rx_d_vld           (rx_d_vld),
    .i_rf_rd_data         (rf_rd_data),
    .i_rf_rd_data_vld     (rf_rd_data_vld),
    .i_alu_out            (alu_out),
    .i_alu_out_vld        (alu_out_vld),
    .o_rf_addr            (o_rf_addr),
    .o_rf_wr_en           (o_rf_wr_en),
    .o_rf_rd_en           (o_rf_rd_en),
    .o_rf_wr_data         (o_rf_wr_data),
    .o_alu_en             (o_alu_en),
    .o_alu_fun            (o_alu_fun),
    .o_clk_gate_en        (o_clk_gate_en),
    .o_uart_rf_send       (o_uart_rf_send),
    .o_uart_send_rf_data  (o_uart_send_rf_data),
    .o_uart_alu_send      (o_uart_alu_send),
    .o_uart_send_alu_data (o_uart_send_alu_data),
    .o_cmd_err            (o_cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ev(input logic [3:0] kind, input logic [7:0] a, input logic [15:0] d);
    return {kind, 4'h0, a, d};
  endfunction

  task automatic sb_pop(input logic [31:0] got);
    logic [31:0] exp;
    if (sb_q.size() == 0) begin
      check("unexpected_event", got, 32'h0);
    end else begin
      exp = sb_q.pop_front();
      $display("event kind=%0d addr=%h data=%h exp=%h", got[31:28], got[23:16], got[15:0], exp);
      check("event", got, exp);
    end
  endtask

  // monitor samples on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (o_rf_wr_en)      sb_pop(ev(K_WR, {4'h0, o_rf_addr}, {8'h0, o_rf_wr_data}));
    if (o_rf_rd_en)      sb_pop(ev(K_RD, {4'h0, o_rf_addr}, 16'h0));
    if (o_alu_en)        sb_pop(ev(K_ALU, 8'h0, {12'h0, o_alu_fun}));
    if (o_uart_rf_send)  sb_pop(ev(K_RFS, 8'h0, {8'h0, o_uart_send_rf_data}));
    if (o_uart_alu_send) sb_pop(ev(K_ALS, 8'h0, o_uart_send_alu_data));
    if (o_cmd_err)       sb_pop(ev(K_ERR, 8'h0, 16'h0));
    if (!o_rf_wr_en && !o_rf_rd_en) check("rf_bus_quiet", {20'h0, o_rf_addr, o_rf_wr_data}, 32'h0);
    if (!o_alu_en) check("alu_fun_quiet", {28'h0, o_alu_fun}, 32'h0);
  end

  // each call occupies the current cycle; time stays at posedge+1
  task automatic send_byte(input logic [7:0] b);
    rx_p_data = b;
    rx_d_vld  = 1'b1;
    @(posedge clk); #1;
    rx_d_vld  = 1'b0;
    rx_p_data = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_rf(input logic [7:0] d);
    rf_rd_data = d;
    rf_rd_data_vld = 1'b1;
    @(posedge clk); #1;
    rf_rd_data_vld = 1'b0;
    rf_rd_data = 8'h00;
  endtask

  task automatic pulse_alu(input logic [15:0] d);
    alu_out = d;
    alu_out_vld = 1'b1;
    @(posedge clk); #1;
    alu_out_vld = 1'b0;
    alu_out = 16'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    rx_p_data = 8'h00; rx_d_vld = 1'b0;
    rf_rd_data = 8'h00; rf_rd_data_vld = 1'b0;
    alu_out = 16'h0; alu_out_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rf_send", {31'h0, o_uart_rf_send}, 32'h0);
    check("rst_alu_send", {31'h0, o_uart_alu_send}, 32'h0);
    check("rst_cmd_err", {31'h0, o_cmd_err}, 32'h0);
    check("rst_rf_data", {24'h0, o_uart_send_rf_data}, 32'h0);
    check("rst_alu_data", {16'h0, o_uart_send_alu_data}, 32'h0);
    check("rst_clk_gate", {31'h0, o_clk_gate_en}, 32'h0);
    rst = 1'b0;
    idle(2);

    // register write
    sb_q.push_back(ev(K_WR, 8'h05, 16'h003C));
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
    idle(2);

    // register read; a stray byte in RD_WAIT must be dropped
    sb_q.push_back(ev(K_RD, 8'h07, 16'h0));
    sb_q.push_back(ev(K_RFS, 8'h0, 16'h005A));
    send_byte(8'hBB); send_byte(8'h07);
    send_byte(8'h55);
    idle(1);
    pulse_rf(8'h5A);
    idle(4);
    check("rf_data_held", {24'h0, o_uart_send_rf_data}, 32'h5A);

    // ALU operation
    sb_q.push_back(ev(K_WR, 8'h00, 16'h0012));
    sb_q.push_back(ev(K_WR, 8'h01, 16'h0034));
    sb_q.push_back(ev(K_ALU, 8'h0, 16'h0001));
    sb_q.push_back(ev(K_ALS, 8'h0, 16'h0046));
    send_byte(8'hCC); send_byte(8'h12); send_byte(8'h34);
    check("clk_gate_fun", {31'h0, o_clk_gate_en}, 32'h1);
    send_byte(8'h01);
    check("clk_gate_alu_wait", {31'h0, o_clk_gate_en}, 32'h1);
    idle(1);
    pulse_alu(16'h0046);
    idle(3);
    check("alu_data_held", {16'h0, o_uart_send_alu_data}, 32'h0046);
    check("clk_gate_idle", {31'h0, o_clk_gate_en}, 32'h0);

    // ALU timeout; a late response after expiry is ignored
    sb_q.push_back(ev(K_ALU, 8'h0, 16'h0002));
    sb_q.push_back(ev(K_ERR, 8'h0, 16'h0));
    send_byte(8'hDD); send_byte(8'h02);
    idle(16);
    pulse_alu(16'hBEEF);
    idle(3);
    check("alu_data_after_timeout", {16'h0, o_uart_send_alu_data}, 32'h0046);

    // response on the last accepted wait cycle wins
    sb_q.push_back(ev(K_ALU, 8'h0, 16'h0002));
    sb_q.push_back(ev(K_ALS, 8'h0, 16'h1234));
    send_byte(8'hDD); send_byte(8'h02);
    idle(15);
    pulse_alu(16'h1234);
    idle(3);

    // bad opcode
    sb_q.push_back(ev(K_ERR, 8'h0, 16'h0));
    send_byte(8'h55);
    idle(3);

    // reset mid-frame, with a byte arriving during reset
    send_byte(8'hAA); send_byte(8'h03);
    rst = 1'b1;
    send_byte(8'h99);
    rst = 1'b0;
    check("rst_clears_rf_data", {24'h0, o_uart_send_rf_data}, 32'h0);
    idle(2);
    sb_q.push_back(ev(K_WR, 8'h03, 16'h0011));
    send_byte(8'hAA); send_byte(8'h03); send_byte(8'h11);
    idle(5);

    check("sb_drained", sb_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ctrl_rx_cmd.md
CTRL_RX_CMD -- requirements
Module: ctrl_rx_cmd

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data byte width.
REQ-002 SHALL have parameter ADDR, default 4, register-file address width.
REQ-003 SHALL have parameter TIMEOUT, default 16, maximum wait cycles for RF/ALU response.
REQ-004 CLK  in  1  single clock, all state updates on rising edge.
REQ-005 RST  in  1  reset, synchronous, active-high.
REQ-006 RX_P_DATA  in  WIDTH  received UART byte.
REQ-007 RX_D_VLD  in  1  one-cycle pulse, RX_P_DATA valid.
REQ-008 RF_RD_DATA  in  WIDTH  / RF_RD_DATA_VLD  in  1  register-file read return.
REQ-009 ALU_OUT  in  2*WIDTH  / ALU_OUT_VLD  in  1  ALU result return.
REQ-010 RF_ADDR  out  ADDR;  RF_WR_EN  out  1;  RF_RD_EN  out  1;  RF_WR_DATA  out  WIDTH  register-file port.
REQ-011 ALU_EN  out  1;  ALU_FUN  out  4;  CLK_GATE_EN  out  1  ALU control.
REQ-012 UART_RF_SEND  out  1;  UART_SEND_RF_DATA  out  WIDTH;  UART_ALU_SEND  out  1;  UART_SEND_ALU_DATA  out  2*WIDTH  to TX sequencer.
REQ-013 CMD_ERR  out  1  one-cycle pulse, bad opcode or timeout.

Function
REQ-014 States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA, OPB, FUN, ALU_WAIT.
REQ-015 IDLE, RX_D_VLD with byte 0xAA -> WR_ADDR; 0xBB -> RD_ADDR; 0xCC -> OPA; 0xDD -> FUN; any other -> stay IDLE, CMD_ERR pulse next cycle.
REQ-016 WR_ADDR: on RX_D_VLD latch addr_reg = byte[ADDR-1:0] -> WR_DATA.
REQ-017 WR_DATA: on RX_D_VLD, same cycle RF_WR_EN=1, RF_ADDR=addr_reg, RF_WR_DATA=byte -> IDLE.
REQ-018 RD_ADDR: on RX_D_VLD, same cycle RF_RD_EN=1, RF_ADDR=byte[ADDR-1:0] -> RD_WAIT.
REQ-019 OPA: on RX_D_VLD, same cycle RF_WR_EN=1, RF_ADDR=0, RF_WR_DATA=byte -> OPB.
REQ-020 OPB: on RX_D_VLD, same cycle RF_WR_EN=1, RF_ADDR=1, RF_WR_DATA=byte -> FUN.
REQ-021 FUN: CLK_GATE_EN=1; on RX_D_VLD, same cycle ALU_EN=1, ALU_FUN=byte[3:0] -> ALU_WAIT.
REQ-022 ALU_WAIT: CLK_GATE_EN=1; on ALU_OUT_VLD capture ALU_OUT into alu_reg -> IDLE; UART_ALU_SEND=1 for exactly the next cycle.
REQ-023 RD_WAIT: on RF_RD_DATA_VLD capture RF_RD_DATA into rf_reg -> IDLE; UART_RF_SEND=1 for exactly the next cycle.
REQ-024 UART_SEND_RF_DATA = rf_reg, UART_SEND_ALU_DATA = alu_reg; held stable until next capture.
REQ-025 Wait counter cleared on entry to RD_WAIT/ALU_WAIT; response in wait cycles 1..TIMEOUT accepted; none by end of cycle TIMEOUT -> IDLE, CMD_ERR pulse next cycle, no SEND pulse.
REQ-026 RX_D_VLD in RD_WAIT/ALU_WAIT ignored (byte dropped); RF_RD_DATA_VLD/ALU_OUT_VLD outside matching wait state ignored.
REQ-027 Response valid on same cycle as TIMEOUT expiry: response wins, no CMD_ERR.
REQ-028 All RF/ALU strobes (RF_WR_EN, RF_RD_EN, ALU_EN) combinational, at most one cycle per accepted byte; RF_ADDR, RF_WR_DATA, ALU_FUN = 0 when strobes low.
REQ-029 CLK_GATE_EN = 0 in all states except FUN and ALU_WAIT.

Reset
REQ-030 RST high at rising edge: state=IDLE, addr_reg, rf_reg, alu_reg, counter = 0; all outputs 0 from next cycle.
REQ-031 RST wins over any simultaneous RX_D_VLD/response; reset mid-frame aborts with no RF write, ALU_EN, SEND or CMD_ERR issued.

Verification
REQ-032 Bytes AA,05,3C -> RF_WR_EN one cycle with RF_ADDR=5, RF_WR_DATA=0x3C; FSM IDLE after.
REQ-033 Bytes BB,07; RF_RD_DATA=0x5A valid 3 cycles later -> RF_RD_EN with RF_ADDR=7, then UART_RF_SEND one cycle, UART_SEND_RF_DATA=0x5A held.
REQ-034 Bytes CC,12,34,01; ALU_OUT=0x0046 valid -> RF writes addr0=0x12, addr1=0x34, ALU_EN with ALU_FUN=1, UART_ALU_SEND pulse, UART_SEND_ALU_DATA=0x0046.
REQ-035 Bytes DD,02, no ALU_OUT_VLD for 16 cycles -> IDLE, CMD_ERR one cycle, no UART_ALU_SEND; repeat with valid on cycle 16 -> accepted, no CMD_ERR.
REQ-036 Byte 0x55 in IDLE -> CMD_ERR pulse, no strobes; bytes AA,03 then RST -> IDLE, no RF_WR_EN, following AA,03,11 writes normally.
